// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: merges pipeline (P) and mult/div (M)
// writebacks into one registered write per cycle, with an M result FIFO and starvation guard.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        p_valid,
  input  logic [4:0]  p_reg,
  input  logic [31:0] p_data,
  output logic        stall_p,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_reg,
  input  logic [31:0] m_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] pending_mask
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [31:0]       wdata_q, wdata_d;

  logic   empty, full, push, pop, p_win;
  entry_t head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CntW'(DEPTH));
    // Held low during reset so no handshake can complete while the FIFO is being cleared.
    m_ready  = !full && !ctrl_reset;
    push     = m_valid && m_ready && (m_reg != 5'd0);
    head     = mem_q[rd_ptr_q];
    pop      = 1'b0;
    p_win    = 1'b0;
    we_d     = 1'b0;
    wreg_d   = 5'd0;
    wdata_d  = 32'd0;

    if (stall_q && !empty) begin
      pop = 1'b1;
    end else if (p_valid && (p_reg != 5'd0)) begin
      p_win   = 1'b1;
      we_d    = 1'b1;
      wreg_d  = p_reg;
      wdata_d = p_data;
    end else if (!empty) begin
      pop = 1'b1;
    end

    if (pop) begin
      we_d    = 1'b1;
      wreg_d  = head.rg;
      wdata_d = head.data;
    end

    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);

    starve_d = starve_q;
    stall_d  = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (p_win) begin
      if (starve_q == StW'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + StW'(1);
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < count_q) begin
        pending_mask[mem_q[rd_ptr_q + PtrW'(i)].rg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{rg: m_reg, data: m_data};
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign stall_p          = stall_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based reference model predicts each
// write and its cycle; a negedge monitor pops and compares whatever the DUT writes.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_reg = '0;
  logic [31:0] p_data = '0;
  logic        stall_p;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .p_valid          (p_valid),
    .p_reg            (p_reg),
    .p_data           (p_data),
    .stall_p          (stall_p),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_reg            (m_reg),
    .m_data           (m_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending_mask     (pending_mask)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rg;
    logic [31:0] d;
  } exp_t;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] d;
  } ent_t;

  exp_t sb[$];      // expected writes, tagged with the cycle they must appear in
  ent_t mq[$];      // model of the M queue contents
  int   starve = 0; // consecutive P wins against a non-empty queue
  bit   mstall = 0; // model of stall_p for the current cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!ctrl_reset) begin
      if (ctrl_writeEnable) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write at cycle %0d: got r%0d=%h, expected no write",
                   cyc, ctrl_writeReg, data_writeReg);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("write_reg", 32'(ctrl_writeReg), 32'(e.rg));
          chk("write_data", data_writeReg, e.d);
        end
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        nvec++;
        nerr++;
        $display("FAIL missing_write at cycle %0d: got no write, expected r%0d=%h",
                 cyc, sb[0].rg, sb[0].d);
        void'(sb.pop_front());
      end
    end
  end

  function automatic void expect_write(input logic [4:0] rg, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.rg  = rg;
    e.d   = d;
    sb.push_back(e);
  endfunction

  // One clock: check registered-state outputs, drive inputs, advance the model by one edge.
  task automatic step(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md);
    logic [31:0] exp_mask;
    bit          empty, full, popped, pwin;
    ent_t        h;
    @(negedge clock);
    empty    = (mq.size() == 0);
    full     = (mq.size() == DEPTH);
    exp_mask = '0;
    foreach (mq[i]) exp_mask[mq[i].rg] = 1'b1;
    chk("m_ready", 32'(m_ready), 32'(!full));
    chk("stall_p", 32'(stall_p), 32'(mstall));
    chk("pending_mask", pending_mask, exp_mask);

    p_valid = pv;
    p_reg   = pr;
    p_data  = pd;
    m_valid = mv;
    m_reg   = mr;
    m_data  = md;

    popped = 0;
    pwin   = 0;
    if (mstall && !empty) begin
      h = mq.pop_front();
      popped = 1;
      expect_write(h.rg, h.d);
    end else if (pv && pr != 0) begin
      pwin = 1;
      expect_write(pr, pd);
    end else if (!empty) begin
      h = mq.pop_front();
      popped = 1;
      expect_write(h.rg, h.d);
    end
    if (mv && !full && mr != 0) mq.push_back('{rg: mr, d: md});

    mstall = 0;
    if (empty || popped) begin
      starve = 0;
    end else if (pwin) begin
      starve++;
      if (starve == STARVE_LIMIT) begin
        starve = 0;
        mstall = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Reset asserted mid-cycle; outputs must collapse at once and the model forgets everything.
  task automatic do_reset();
    @(negedge clock);
    #2;
    ctrl_reset = 1'b1;
    p_valid    = 1'b0;
    m_valid    = 1'b0;
    #1;
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_stall", 32'(stall_p), 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    sb.delete();
    mq.delete();
    starve = 0;
    mstall = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_m_ready_held", 32'(m_ready), 32'd0);
    ctrl_reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("init_we", 32'(ctrl_writeEnable), 32'd0);
    chk("init_m_ready", 32'(m_ready), 32'd0);
    chk("init_pending", pending_mask, 32'd0);
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;

    // P only
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    idle(2);
    // Simultaneous P and M
    step(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    idle(3);
    // r0 drop with r9 queued ahead
    step(0, 5'd0, 32'd0, 1, 5'd9, 32'h9);
    step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h1);
    idle(3);
    // Full plus starvation, P hammering r1
    for (int i = 0; i < 24; i++) begin
      step(1, 5'd1, $urandom, (i < 4), 5'(10 + i), 32'(32'hA0 + i));
    end
    idle(4);
    // Push and pop in the same cycle at count 3
    for (int i = 0; i < 3; i++) step(1, 5'd1, $urandom, 1, 5'(20 + i), 32'(i));
    step(0, 5'd0, 32'd0, 1, 5'd23, 32'h23);
    idle(6);
    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 5'd2, $urandom, 1, 5'(24 + i), 32'(i));
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    do_reset();
    idle(3);

    // Random traffic: balanced, then P-heavy to force full queue and stalls
    for (int i = 0; i < 900; i++) begin
      int unsigned pprob;
      int unsigned mprob;
      pprob = (i < 400) ? 50 : 95;
      mprob = (i < 400) ? 50 : 70;
      step($urandom_range(0, 99) < pprob, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < mprob, 5'($urandom_range(0, 31)), $urandom);
      if (i == 650) do_reset();
    end
    idle(DEPTH + 4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
